// File: rtl/arm_mem_arbiter.sv
// Shared memory-port arbiter between instruction fetch (IF) and load/store (LS).
// One transaction in flight; LS has priority, bounded by a streak limit so fetch cannot starve.
module arm_mem_arbiter #(
  parameter int ADDR_W        = 30,
  parameter int DATA_W        = 32,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  localparam logic [3:0] MAX_S = 4'(MAX_LS_STREAK);

  state_t            state_q, state_d;
  logic              owner_ls_q, owner_ls_d;
  logic [3:0]        streak_q, streak_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ready_q, if_ready_d;
  logic              ls_ready_q, ls_ready_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;

  always_comb begin
    state_d     = state_q;
    owner_ls_d  = owner_ls_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_ready_d  = 1'b0;
    ls_ready_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ls_req && (!if_req || (streak_q < MAX_S))) begin
          owner_ls_d  = 1'b1;
          mem_addr_d  = ls_addr;
          mem_we_d    = ls_we;
          mem_wdata_d = ls_wdata;
          mem_req_d   = 1'b1;
          state_d     = ST_WAIT;
          // Streak only counts LS wins that actually made a fetch wait
          if (!if_req)                streak_d = 4'd0;
          else if (streak_q != MAX_S) streak_d = streak_q + 4'd1;
        end else if (if_req) begin
          owner_ls_d = 1'b0;
          mem_addr_d = if_addr;
          mem_we_d   = 1'b0;
          mem_req_d  = 1'b1;
          state_d    = ST_WAIT;
          streak_d   = 4'd0;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_DONE;
          if (owner_ls_q) begin
            ls_ready_d = 1'b1;
            // mem_we_q still reflects the granted direction here
            if (!mem_we_q) ls_rdata_d = mem_rdata;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_ls_q  <= 1'b0;
      streak_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      ls_ready_q  <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_ls_q  <= owner_ls_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ready_q  <= if_ready_d;
      ls_ready_q  <= ls_ready_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign if_rdata  = if_rdata_q;
  assign ls_ready  = ls_ready_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Directed bench for arm_mem_arbiter: one task per scenario, outputs sampled on the falling edge.
module tb_arm_mem_arbiter;
  logic        clk;
  logic        rst;
  logic        if_req;
  logic [29:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [29:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ready;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  logic        ack_manual;
  logic        auto_ack;
  logic [31:0] rdata_manual;

  int checks = 0;
  int passes = 0;

  // Zero-wait memory in auto mode returns a known function of the address
  assign mem_ack   = ack_manual | (auto_ack & mem_req);
  assign mem_rdata = auto_ack ? ({2'b00, mem_addr} ^ 32'hA5A5_0000) : rdata_manual;

  arm_mem_arbiter #(.ADDR_W(30), .DATA_W(32), .MAX_LS_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({mem_req, mem_we, busy, if_ready, ls_ready} !== 5'b0)
      $display("FAIL reset_ctrl: got %b expected 00000", {mem_req, mem_we, busy, if_ready, ls_ready});
    else passes++;
    checks++; if ({if_rdata, ls_rdata, mem_wdata, mem_addr} !== '0)
      $display("FAIL reset_data: got %h/%h/%h/%h expected all 0", if_rdata, ls_rdata, mem_wdata, mem_addr);
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else passes++;
  endtask

  task automatic test_if_only();
    int hi = 0;
    if_addr = 30'h10; if_req = 1'b1;
    @(negedge clk); hi = hi + (mem_req ? 1 : 0);
    checks++; if (mem_addr !== 30'h10) $display("FAIL if_addr: got %h expected 10", mem_addr); else passes++;
    checks++; if (mem_we !== 1'b0) $display("FAIL if_we: got %b expected 0", mem_we); else passes++;
    @(negedge clk); hi = hi + (mem_req ? 1 : 0);
    @(negedge clk); hi = hi + (mem_req ? 1 : 0);
    checks++; if (busy !== 1'b1) $display("FAIL if_busy_wait: got %b expected 1", busy); else passes++;
    ack_manual = 1'b1; rdata_manual = 32'hE3A01005;
    @(negedge clk);
    ack_manual = 1'b0;
    checks++; if (hi !== 3 || mem_req !== 1'b0)
      $display("FAIL if_req_len: got %0d cycles (now %b) expected 3 (now 0)", hi, mem_req);
    else passes++;
    checks++; if ({if_ready, ls_ready} !== 2'b10) $display("FAIL if_ready: got %b expected 10", {if_ready, ls_ready}); else passes++;
    checks++; if (if_rdata !== 32'hE3A01005) $display("FAIL if_rdata: got %h expected e3a01005", if_rdata); else passes++;
    if_req = 1'b0;
    @(negedge clk);
    checks++; if ({if_ready, busy} !== 2'b00) $display("FAIL if_after: got %b expected 00", {if_ready, busy}); else passes++;
  endtask

  task automatic test_simultaneous();
    int ls_t = -1;
    int if_t = -1;
    logic both = 1'b0;
    auto_ack = 1'b1;
    if_req = 1'b1; if_addr = 30'h20;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 30'h200;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (if_ready && ls_ready) both = 1'b1;
      if (ls_ready && ls_t < 0) begin ls_t = c; ls_req = 1'b0; end
      if (if_ready && if_t < 0) begin if_t = c; if_req = 1'b0; end
    end
    checks++; if (ls_t !== 2) $display("FAIL simul_ls_first: got cycle %0d expected 2", ls_t); else passes++;
    checks++; if (if_t !== 5) $display("FAIL simul_if_second: got cycle %0d expected 5", if_t); else passes++;
    checks++; if (ls_rdata !== 32'hA5A50200) $display("FAIL simul_ls_rdata: got %h expected a5a50200", ls_rdata); else passes++;
    checks++; if (if_rdata !== 32'hA5A50020) $display("FAIL simul_if_rdata: got %h expected a5a50020", if_rdata); else passes++;
    checks++; if (both !== 1'b0) $display("FAIL simul_both_ready: got %b expected 0", both); else passes++;
  endtask

  task automatic test_starvation();
    int g = 0;
    logic exp_ls;
    logic got_ls;
    logic both = 1'b0;
    ls_addr = 30'h100; ls_we = 1'b0; if_addr = 30'h40;
    ls_req = 1'b1; if_req = 1'b1;
    for (int c = 0; c < 60 && g < 10; c++) begin
      @(negedge clk);
      if (if_ready && ls_ready) both = 1'b1;
      if (mem_req) begin
        exp_ls = (g != 4 && g != 9);
        got_ls = (mem_addr == 30'h100);
        checks++; if (got_ls !== exp_ls)
          $display("FAIL streak_grant%0d: got ls=%b expected ls=%b", g, got_ls, exp_ls);
        else passes++;
        g++;
      end
    end
    ls_req = 1'b0; if_req = 1'b0;
    checks++; if (g !== 10) $display("FAIL streak_count: got %0d grants expected 10", g); else passes++;
    repeat (2) @(negedge clk);
    checks++; if ({busy, both} !== 2'b00) $display("FAIL streak_end: got %b expected 00", {busy, both}); else passes++;
  endtask

  task automatic test_store();
    auto_ack = 1'b0;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 30'h5;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1) $display("FAIL load_req: got %b expected 1", mem_req); else passes++;
    ack_manual = 1'b1; rdata_manual = 32'h12345678;
    @(negedge clk);
    ack_manual = 1'b0;
    checks++; if ({ls_ready, ls_rdata} !== {1'b1, 32'h12345678})
      $display("FAIL load_data: got %b/%h expected 1/12345678", ls_ready, ls_rdata);
    else passes++;
    ls_req = 1'b0;
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 30'h3FF; ls_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 30'h3FF, 32'hDEADBEEF})
      $display("FAIL store_bus: got %b %b %h %h expected 1 1 3ff deadbeef", mem_req, mem_we, mem_addr, mem_wdata);
    else passes++;
    @(negedge clk);
    checks++; if ({mem_req, mem_we, mem_wdata} !== {1'b1, 1'b1, 32'hDEADBEEF})
      $display("FAIL store_hold: got %b %b %h expected 1 1 deadbeef", mem_req, mem_we, mem_wdata);
    else passes++;
    ack_manual = 1'b1; rdata_manual = 32'hFFFFFFFF;
    @(negedge clk);
    ack_manual = 1'b0;
    checks++; if ({ls_ready, if_ready, mem_we, mem_req} !== 4'b1000)
      $display("FAIL store_done: got %b expected 1000", {ls_ready, if_ready, mem_we, mem_req});
    else passes++;
    checks++; if (ls_rdata !== 32'h12345678) $display("FAIL store_rdata: got %h expected 12345678", ls_rdata); else passes++;
    checks++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL store_wdata_kept: got %h expected deadbeef", mem_wdata); else passes++;
    ls_req = 1'b0; ls_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    logic seen = 1'b0;
    logic got = 1'b0;
    if_req = 1'b1; if_addr = 30'h30;
    repeat (2) @(negedge clk);
    checks++; if (mem_req !== 1'b1) $display("FAIL rstw_req_before: got %b expected 1", mem_req); else passes++;
    rst = 1'b1;
    #1;
    checks++; if ({mem_req, busy} !== 2'b00) $display("FAIL rstw_async: got %b expected 00", {mem_req, busy}); else passes++;
    @(negedge clk);
    if_req = 1'b0; rst = 1'b0;
    ack_manual = 1'b1; rdata_manual = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk);
      if (if_ready || ls_ready || busy) seen = 1'b1;
    end
    ack_manual = 1'b0;
    checks++; if (seen !== 1'b0) $display("FAIL rstw_no_ready: got %b expected 0", seen); else passes++;
    checks++; if (if_rdata !== 32'h0) $display("FAIL rstw_if_rdata: got %h expected 0", if_rdata); else passes++;
    auto_ack = 1'b1;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 30'h7;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (ls_ready) begin got = 1'b1; ls_req = 1'b0; end
    end
    ls_req = 1'b0;
    checks++; if ({got, ls_rdata} !== {1'b1, 32'hA5A50007})
      $display("FAIL rstw_new_ls: got %b/%h expected 1/a5a50007", got, ls_rdata);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_spurious();
    logic seen = 1'b0;
    auto_ack = 1'b0; ack_manual = 1'b1; rdata_manual = 32'hFFFFFFFF;
    repeat (3) begin
      @(negedge clk);
      if (if_ready || ls_ready || busy || mem_req) seen = 1'b1;
    end
    ack_manual = 1'b0;
    checks++; if (seen !== 1'b0) $display("FAIL spur_activity: got %b expected 0", seen); else passes++;
    checks++; if ({ls_rdata, if_rdata} !== {32'hA5A50007, 32'h0})
      $display("FAIL spur_rdata: got %h/%h expected a5a50007/0", ls_rdata, if_rdata);
    else passes++;
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    ack_manual = 1'b0; auto_ack = 1'b0; rdata_manual = '0;
    test_reset();
    test_if_only();
    test_simultaneous();
    test_starvation();
    test_store();
    test_reset_mid_wait();
    test_spurious();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
